// File: rtl/controle_rega.sv
// -----------------------------------------------------------------------------
// controle_rega -- three-zone irrigation controller
//
// Arbitrates level requests from three zones round-robin. It opens the valve of
// the granted zone and counts the watering time down in mm:ss, one second per
// tick_1hz pulse. It reports normal completion with a one-cycle fim pulse.
//
// Ports
//   clock       system clock; all state updates on its rising edge
//   rst         asynchronous, active-high reset
//   tick_1hz    one-cycle pulse per second
//   req[2:0]    level watering requests, one bit per zone
//   dur_min     requested duration in minutes (10..15 clamp to 9)
//   stop        abort of the active watering cycle
//   pausa       (only with CONTROLE_REGA_PAUSA_EN) hold countdown, close valve
//   valvula     one-hot valve drive, open only while watering
//   zona        index of the granted zone
//   ocupado     high whenever the controller is not idle
//   fim         one-cycle pulse on normal completion
//   QMinutos / QDSegundos / QUSegundos   remaining time m : s(tens) s(units)
//
// Optional feature: define CONTROLE_REGA_PAUSA_EN to add the pausa input.
// -----------------------------------------------------------------------------
module controle_rega (
  input  logic       clock,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic [2:0] req,
  input  logic [3:0] dur_min,
  input  logic       stop,
`ifdef CONTROLE_REGA_PAUSA_EN
  input  logic       pausa,
`endif
  output logic [2:0] valvula,
  output logic [1:0] zona,
  output logic       ocupado,
  output logic       fim,
  output logic [3:0] QMinutos,
  output logic [2:0] QDSegundos,
  output logic [3:0] QUSegundos
);

  typedef enum logic [1:0] {IDLE, CARGA, REGA, FIM} state_t;

  state_t     state_q, state_d;
  logic [1:0] ult_q, ult_d;
  logic [1:0] zona_q, zona_d;
  logic [3:0] min_q, min_d;
  logic [2:0] ds_q, ds_d;
  logic [3:0] us_q, us_d;
  logic [2:0] valv_q, valv_d;
  logic       fim_q, fim_d;
  logic       ocup_q, ocup_d;

  logic       pausa_w;
  logic [1:0] grant_w;
  logic       tick_ok;
  logic       last_sec;

`ifdef CONTROLE_REGA_PAUSA_EN
  assign pausa_w = pausa;
`else
  assign pausa_w = 1'b0;
`endif

  function automatic logic [1:0] inc3(input logic [1:0] z);
    inc3 = (z == 2'd2) ? 2'd0 : z + 2'd1;
  endfunction

  function automatic logic [2:0] onehot(input logic [1:0] z);
    case (z)
      2'd0:    onehot = 3'b001;
      2'd1:    onehot = 3'b010;
      2'd2:    onehot = 3'b100;
      default: onehot = 3'b000;
    endcase
  endfunction

  function automatic logic [3:0] clamp_min(input logic [3:0] d);
    clamp_min = (d > 4'd9) ? 4'd9 : d;
  endfunction

  // Round-robin: look at ult+1, then ult+2, and finally ult itself. This is
  // only called with req != 0, so the last fallback always holds a request.
  function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] last);
    logic [1:0] n1;
    logic [1:0] n2;
    n1 = inc3(last);
    n2 = inc3(n1);
    if (r[n1])      rr_pick = n1;
    else if (r[n2]) rr_pick = n2;
    else            rr_pick = last;
  endfunction

  assign grant_w  = rr_pick(req, ult_q);
  assign tick_ok  = tick_1hz & ~pausa_w;
  assign last_sec = (min_q == 4'd0) && (ds_q == 3'd0) && (us_q == 4'd1);

  always_comb begin
    state_d = state_q;
    ult_d   = ult_q;
    zona_d  = zona_q;
    min_d   = min_q;
    ds_d    = ds_q;
    us_d    = us_q;

    case (state_q)
      IDLE: begin
        if (req != 3'b000) begin
          zona_d  = grant_w;
          min_d   = clamp_min(dur_min);
          ds_d    = 3'd0;
          us_d    = 4'd0;
          state_d = CARGA;
        end
      end
      CARGA: begin
        // A zero duration skips watering entirely; the valve never opens.
        state_d = (min_q != 4'd0) ? REGA : FIM;
      end
      REGA: begin
        // stop has priority over a coincident final tick.
        if (stop) begin
          ult_d   = zona_q;
          state_d = IDLE;
        end else if (tick_ok) begin
          if (last_sec) begin
            us_d    = 4'd0;
            state_d = FIM;
          end else if (us_q != 4'd0) begin
            us_d = us_q - 4'd1;
          end else begin
            us_d = 4'd9;
            if (ds_q != 3'd0) begin
              ds_d = ds_q - 3'd1;
            end else begin
              ds_d  = 3'd5;
              min_d = min_q - 4'd1;
            end
          end
        end
      end
      FIM: begin
        ult_d   = zona_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it.
    fim_d  = (state_d == FIM);
    ocup_d = (state_d != IDLE);
    valv_d = ((state_d == REGA) && !pausa_w) ? onehot(zona_d) : 3'b000;
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ult_q   <= 2'd2;  // makes zone 0 win the first arbitration
      zona_q  <= 2'd0;
      min_q   <= 4'd0;
      ds_q    <= 3'd0;
      us_q    <= 4'd0;
      valv_q  <= 3'b000;
      fim_q   <= 1'b0;
      ocup_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ult_q   <= ult_d;
      zona_q  <= zona_d;
      min_q   <= min_d;
      ds_q    <= ds_d;
      us_q    <= us_d;
      valv_q  <= valv_d;
      fim_q   <= fim_d;
      ocup_q  <= ocup_d;
    end
  end

  assign valvula    = valv_q;
  assign zona       = zona_q;
  assign ocupado    = ocup_q;
  assign fim        = fim_q;
  assign QMinutos   = min_q;
  assign QDSegundos = ds_q;
  assign QUSegundos = us_q;

endmodule
